// File: rtl/control_sequencer.sv
// Instruction-level control unit for one matrix-multiply core: fetches 16-bit
// instructions over a req/ack port, decodes them and drives datapath strobes.
module control_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               mem_ack,
  input  logic               logic_in,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [1:0]         branch_sel,
  output logic [2:0]         alu_op,
  output logic               alu_en,
  output logic               reg_we,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_JNZ   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  // state is the debug view of the FSM for checkers.
  state_t state;
  state_t state_next;

  logic [INSTR_W-1:0] ir;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  operand;
  logic               is_branch;
  logic               ir_unused;

  assign opcode    = ir[INSTR_W-1 -: 4];
  assign operand   = ir[ADDR_W-1:0];
  assign is_branch = (opcode == OP_JMP) || (opcode == OP_JZ) || (opcode == OP_JNZ);
  assign ir_unused = ^ir;

  assign busy   = (state != S_IDLE) && (state != S_HALTED);
  assign halted = (state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory handshake: mem_req rises with the address and stays high, address
  // and mem_we unchanged, until the cycle in which mem_ack is sampled high;
  // that cycle completes the transfer and mem_req drops on the next cycle.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_MUL: begin
            alu_en     = 1'b1;
            reg_we     = 1'b1;
            state_next = S_FETCH;
          end
          OP_LOAD, OP_STORE: state_next = S_MEM;
          OP_HALT:           state_next = S_HALTED;
          default:           state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = operand;
        mem_we   = (opcode == OP_STORE);
        if (mem_ack) begin
          reg_we     = (opcode == OP_LOAD);
          state_next = S_FETCH;
        end
      end
      S_HALTED: begin
        state_next = S_HALTED;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      ir         <= '0;
      branch_sel <= 2'd0;
      alu_op     <= 3'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir <= instr_in;
            pc <= pc + PC_ONE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_JMP: branch_sel <= 2'd0;
            OP_JZ:  branch_sel <= 2'd1;
            OP_JNZ: branch_sel <= 2'd2;
            OP_ADD: alu_op     <= 3'd0;
            OP_SUB: alu_op     <= 3'd1;
            OP_MUL: alu_op     <= 3'd2;
            default: ;
          endcase
        end
        S_EXEC: begin
          // branch_sel has been stable since DECODE, so logic_in is settled.
          if (is_branch && logic_in) pc <= operand;
        end
        default: ;
      endcase
    end
  end

endmodule
